// File: rtl/master_fsm.sv
// -----------------------------------------------------------------------------
// master_fsm
//   Byte FIFO feeding a req/ack master handshake. Bytes pushed with wr_en are
//   queued. The FIFO head is presented on data and offered to the slave by
//   raising req. A slave ack pops the head. The master then waits in RELEASE
//   until ack drops before offering the next byte. If no ack arrives within
//   TIMEOUT cycles, the block parks in ERR until reset.
//
// Parameters
//   DEPTH    FIFO entries, 2..8
//   TIMEOUT  maximum cycles req is held high awaiting ack, 2..255
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   wr_en    push wr_data into the FIFO (dropped when full)
//   wr_data  byte to enqueue
//   ack      acknowledge from the slave
//   req      registered request to the slave, high only in SEND
//   data     FIFO head byte
//   full     count equals DEPTH
//   count    number of occupied entries
//   busy     FSM is not IDLE
//   done     one-cycle pulse when the FIFO has drained after a release
//   err      handshake timeout (held until reset)
// -----------------------------------------------------------------------------
module master_fsm #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       ack,
    output logic       req,
    output logic [7:0] data,
    output logic       full,
    output logic [3:0] count,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [7:0]      WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [3:0]      COUNT_FULL = 4'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [7:0]       wait_cnt;
    logic             push;
    logic             pop;

    // Circular pointer advance: DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A write while full is dropped. A pop happens only on an acked SEND cycle.
    assign push = wr_en && !full;
    assign pop  = (state == SEND) && ack;

    // The head entry cannot be overwritten while it is offered. In SEND the
    // FIFO holds at least one entry, so wr_ptr != rd_ptr unless full, and
    // writes are dropped when full.
    assign data = mem[rd_ptr];

    // ------------------------------------------------------------------ state
    // NOTE: sequential state uses non-blocking (<=) assignments so every flop
    // samples pre-edge values; blocking (=) here would create order-dependent
    // simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        // NOTE: default assignment first, so every path assigns state_nxt and
        // no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: begin
                if (count != 4'd0) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (ack) begin
                    state_nxt = RELEASE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ERR;
                end
            end
            RELEASE: begin
                if (!ack) begin
                    state_nxt = IDLE;
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy = (state != IDLE);
        err  = (state == ERR);
        full = (count == COUNT_FULL);
    end

    // req is registered from the next state, so it is high exactly while the
    // FSM sits in SEND and never glitches on state decode.
    // done fires after a RELEASE->IDLE edge taken with the FIFO empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req  <= 1'b0;
            done <= 1'b0;
        end else begin
            req  <= (state_nxt == SEND);
            done <= (state == RELEASE) && !ack && (count == 4'd0);
        end
    end

    // Wait counter: zero outside SEND, so it is clear on every SEND entry.
    // It counts un-acked SEND cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 8'd0;
        end else if ((state == SEND) && !ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= 8'd0;
        end
    end

    // ------------------------------------------------------------------- FIFO
    // NOTE: the storage array is reset because its contents must read 0x00
    // after reset. This rules out mapping it onto a RAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Push and pop on the same edge leave count unchanged.
            if (push && !pop) begin
                count <= count + 4'd1;
            end else if (pop && !push) begin
                count <= count - 4'd1;
            end
        end
    end

endmodule

// File: doc/master_fsm.md
MASTER_FSM -- requirements
Module: master_fsm

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning payload FIFO entries; legal range is 2..8.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles req is held high awaiting ack; legal range is 2..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port wr_en, input, 1 bit: push wr_data into the FIFO.
REQ-006 The block SHALL have port wr_data, input, 8 bits: byte to enqueue.
REQ-007 The block SHALL have port ack, input, 1 bit: acknowledge from the downstream slave handshake.
REQ-008 The block SHALL have port req, output, 1 bit, registered: request to the slave.
REQ-009 The block SHALL have port data, output, 8 bits: FIFO head byte presented to the slave.
REQ-010 The block SHALL have port full, output, 1 bit: set when count equals DEPTH.
REQ-011 The block SHALL have port count, output, 4 bits: number of occupied FIFO entries.
REQ-012 The block SHALL have port busy, output, 1 bit: set when the state is not IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when the FIFO has drained.
REQ-014 The block SHALL have port err, output, 1 bit: sticky flag for a handshake timeout.

Function
REQ-015 The FIFO SHALL be circular with wr_ptr/rd_ptr wrapping DEPTH-1 -> 0; a write while full is dropped with no state change.
REQ-016 A write and a pop on the same edge SHALL both take effect, leaving count unchanged.
REQ-017 data SHALL equal mem[rd_ptr] at all times and SHALL be stable whenever req=1.
REQ-018 The FSM SHALL have exactly four states: IDLE, SEND, RELEASE and ERR; req SHALL be 1 only in SEND.
REQ-019 IDLE SHALL go to SEND when count != 0, otherwise remain in IDLE; ack in IDLE is ignored.
REQ-020 On entering SEND the wait counter SHALL clear; each SEND cycle with ack=0 SHALL increment it.
REQ-021 In SEND with ack=1 the FSM SHALL go to RELEASE and pop one entry on the same edge.
REQ-022 In SEND with ack=0 and wait counter = TIMEOUT-1 the FSM SHALL go to ERR with no pop, so req is high for exactly TIMEOUT cycles.
REQ-023 In RELEASE the FSM SHALL go to IDLE when ack=0, and SHALL hold RELEASE while ack=1.
REQ-024 done SHALL pulse for one cycle after the RELEASE->IDLE edge when count = 0 at that edge.
REQ-025 ERR SHALL be left only by reset; in ERR, req=0, err=1, FIFO writes are still accepted and no pops occur.
REQ-026 Per-byte latency: a byte written to an empty idle FIFO at edge N SHALL produce req=1 after edge N+1.
REQ-027 Per-byte throughput SHALL be 5 cycles when paired with the team's 2-cycle-ack slave.

Reset
REQ-028 rst_n=0 SHALL immediately force all of the following, regardless of clock: state IDLE; wr_ptr, rd_ptr and count 0; FIFO contents 0x00; req=0; done=0; err=0; full=0; busy=0; data=0x00.
REQ-029 Reset asserted mid-handshake SHALL drop req asynchronously and discard all queued bytes.
REQ-030 After rst_n rises, the first state change SHALL occur on the next clk rising edge.

Verification
REQ-031 Single byte: write 0xA5 to an empty FIFO, slave model connected -> req rises one cycle later; slave last_byte=0xA5; one done pulse; count=0.
REQ-032 Burst: write 0x11,0x22,0x33,0x44 back-to-back -> full=1 after the 4th write; slave receives the bytes in that order at 5-cycle spacing; exactly one done pulse, after 0x44.
REQ-033 Overflow: 5 writes with no ack (slave held in reset) -> 5th byte dropped, count=4; after the slave is released, 0x11..0x44 are delivered and the 5th byte never appears.
REQ-034 Timeout: ack tied 0, write 0x5A -> req high exactly 16 cycles, then req=0, err=1, busy=1, count=1 until rst_n.
REQ-035 Simultaneous events: write on the same edge as a pop at count=2 -> count stays 2 and the byte order is preserved.
REQ-036 Async reset: assert rst_n=0 mid-clock while req=1 and count=3 -> req, count and err are 0 before the next clk edge; the next write restarts normal operation.
